// File: rtl/rca_sum_accumulator.sv
// Accumulates a programmed number of rca sums into a wider register and
// presents the total over a valid/ready handshake, with a sticky overflow flag.
module rca_sum_accumulator #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned ACC_W   = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_beats,
    input  logic [WIDTH:0]     i_in_sum,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic [ACC_W-1:0]   o_acc_out,
    output logic               o_acc_valid,
    input  logic               i_acc_ready,
    output logic               o_ovf,
    output logic               o_busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] w_remaining_next;
    logic               r_ovf;
    logic               w_ovf_next;
    logic [ACC_W:0]     w_sum;

    // One extra bit on the adder exposes the carry out of bit ACC_W-1.
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(i_in_sum);

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_remaining_next = r_remaining;
        w_ovf_next       = r_ovf;
        o_in_ready       = 1'b0;
        o_acc_valid      = 1'b0;
        o_busy           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_remaining_next = i_beats;
                    w_acc_next       = '0;
                    w_ovf_next       = 1'b0;
                    w_state_next     = (i_beats == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid) begin
                    w_acc_next       = w_sum[ACC_W-1:0];
                    w_ovf_next       = r_ovf | w_sum[ACC_W];
                    w_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == COUNT_W'(1)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                o_acc_valid = 1'b1;
                o_busy      = 1'b1;
                if (i_acc_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_remaining <= w_remaining_next;
            r_ovf       <= w_ovf_next;
        end
    end

    assign o_acc_out = r_acc;
    assign o_ovf     = r_ovf;

endmodule

// File: doc/rca_sum_accumulator.md
# rca_sum_accumulator

Sequential stage directly downstream of the `rca` ripple-carry adder. It consumes a stream of `WIDTH+1`-bit sums over a valid/ready handshake, accumulates a programmed number of them into a wider register, and presents the total with a second valid/ready handshake. A sticky flag records accumulator overflow.

## Interface

Parameters:
- `WIDTH`, 4, operand width of the upstream `rca`; input sums are `WIDTH+1` bits.
- `COUNT_W`, 4, width of the beat-count field; maximum of 2^COUNT_W−1 beats per run.
- `ACC_W`, 9, accumulator width; arithmetic is modulo 2^ACC_W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run; sampled only in IDLE.
- `beats`  in  COUNT_W  number of sums to accumulate; sampled with `start`.
- `in_sum`  in  WIDTH+1  sum word from `rca.out`.
- `in_valid`  in  1  `in_sum` is valid.
- `in_ready`  out  1  block accepts `in_sum` this cycle.
- `acc_out`  out  ACC_W  accumulated total.
- `acc_valid`  out  1  `acc_out` is final.
- `acc_ready`  in  1  downstream accepts `acc_out`.
- `ovf`  out  1  sticky: at least one addition in this run carried out of bit ACC_W−1.
- `busy`  out  1  state is not IDLE.

## Operation

- States: IDLE, ACCUM, DONE.
- Internal registers: `acc` (drives `acc_out`), `remaining` (COUNT_W bits), `ovf`.
- IDLE:
  - `in_ready`=0, `acc_valid`=0, `busy`=0.
  - When `start`=1: load `remaining`←`beats`, clear `acc`←0 and `ovf`←0.
  - Next state is DONE if `beats`==0, else ACCUM.
- ACCUM:
  - `in_ready`=1, `busy`=1.
  - On `in_valid && in_ready`: `acc`←(`acc` + zero-extended `in_sum`) mod 2^ACC_W, and `ovf`←`ovf` | carry-out.
  - On the same handshake, `remaining`←`remaining`−1. If `remaining`==1, go to DONE.
  - With no handshake, all state holds.
- DONE:
  - `acc_valid`=1, `busy`=1, `in_ready`=0.
  - `acc_out` and `ovf` stay stable until `acc_valid && acc_ready`, then go to IDLE.
- `start` is ignored in ACCUM and DONE, including the cycle the DONE handshake completes.
- `acc_out` and `ovf` keep their last values in IDLE until the next accepted `start` clears them.
- `in_ready`, `acc_valid` and `busy` are decoded combinationally from state only, never from inputs.
- Input data values are never checked. Any `in_sum` value, including 2^(WIDTH+1)−1, is accepted.

## Timing

- Reset (`rst`=1 at an edge): state←IDLE; `acc`=0, `remaining`=0, `ovf`=0. Outputs after reset: `acc_out`=0, `ovf`=0, `in_ready`=0, `acc_valid`=0, `busy`=0.
- `rst` has priority over every other input in any state. Reset during ACCUM or DONE discards the run with no result handshake.
- Throughput: one sum accepted per cycle while in ACCUM.
- Latency, counting the cycle `start` is sampled as cycle 0:
  - ACCUM occupies cycle 1 onward.
  - With `in_valid` held high, beat k is accepted at the end of cycle k.
  - `acc_valid` rises in cycle N+1 for `beats`=N.
  - `beats`=0 gives `acc_valid` in cycle 1 with `acc_out`=0.
- Last accepted beat to `acc_valid`: one cycle.
- Result handshake to IDLE: one cycle. Earliest next `start` is sampled the cycle after the DONE handshake.
- `ovf` is updated in the same edge as the addition that overflows.

## Test plan

- Reset, then `start`, `beats`=3, sums 5, 7, 30 with `in_valid` held high → `acc_valid` in cycle 4, `acc_out`=42, `ovf`=0, `busy` falls one cycle after the `acc_ready` handshake.
- `start` with `beats`=0 → `in_ready` never asserts, `acc_valid` in cycle 1 with `acc_out`=0, `ovf`=0.
- `beats`=15, all sums 31:
  - default `ACC_W`=9 → `acc_out`=465, `ovf`=0.
  - `ACC_W`=8 → `acc_out`=209, `ovf`=1.
- Backpressure: `beats`=4, `in_valid` toggling 1,0,0,1,1,0,1 with sums 1,2,3,4, then `acc_ready` held low 5 cycles → `acc_out`=10, `acc_valid` and `acc_out` stable all 5 cycles, IDLE one cycle after `acc_ready` rises.
- `start` pulsed in ACCUM with `beats`=1, and again in DONE → both ignored; `remaining` and `acc` unchanged, run completes with its original count.
- `rst` asserted in ACCUM after 2 of 5 beats → next cycle all outputs are 0 and state is IDLE. A following `start`, `beats`=1, sum 9 → `acc_out`=9.
